uart_frame_rx: RTL and testbench
================================

Name: uart_frame_rx

Overview:
Reader on the RX side of the UART unit's FIFO interface. It pops bytes from the RX FIFO and parses fixed 4-byte game frames (SYNC, TYPE, ARG, CHK). It validates each frame and emits one-cycle move/new-game strobes to the game controller, or an error strobe with a code. It is the consumer end of the rx_empty / rd_uart / r_data handshake.

Parameters:
TIMEOUT_CYC, 2_000_000, max clk cycles allowed between consecutive bytes inside a frame (20 ms at 100 MHz)
TO_BITS, 21, width of the inter-byte timeout counter; must satisfy 2^TO_BITS > TIMEOUT_CYC

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
rx_empty  input  1  RX FIFO empty flag
r_data  input  8  RX FIFO head word; valid whenever rx_empty=0 (first-word-fall-through)
rd_uart  output  1  pop strobe to RX FIFO; combinational
move_valid  output  1  one-cycle strobe: valid move frame received
move_cell  output  4  board cell 0..8; held until next move_valid
move_player  output  2  1=X, 2=O; held until next move_valid
new_game  output  1  one-cycle strobe: valid new-game frame received
err  output  1  one-cycle strobe: frame rejected
err_code  output  3  1=checksum, 2=bad type, 3=bad arg, 4=timeout; held until next err
frames_ok  output  8  saturating count of accepted frames (see Optional Feature)
frames_err  output  8  saturating count of rejected frames (see Optional Feature)

Behaviour:
- Frame format: SYNC=0xA5; TYPE (0x01 move, 0x02 new-game); ARG; CHK = TYPE ^ ARG.
- Move ARG: [7:4]=player (1 or 2), [3:0]=cell (0..8). New-game ARG must be 0x00.
- FSM states: S_HUNT, S_TYPE, S_ARG, S_CHK. Byte accepted in any state when rx_empty=0; rd_uart = ~rx_empty & ~reset. Throughput is at most one byte per cycle.
- S_HUNT: byte==0xA5 -> S_TYPE; any other byte is popped and dropped silently, no err.
- S_TYPE: latch TYPE -> S_ARG. S_ARG: latch ARG -> S_CHK.
- S_CHK: evaluate and return to S_HUNT. Checks in priority order: checksum mismatch -> code 1; TYPE not 0x01/0x02 -> code 2; bad player, cell>8, or new-game ARG!=0 -> code 3. Otherwise the frame is valid.
- A 0xA5 arriving in S_TYPE/S_ARG/S_CHK is treated as data, not a resync.
- All outputs are registered, except rd_uart. Strobes assert exactly 1 cycle after the cycle in which CHK is popped.
- move_cell/move_player update only on a valid move frame. err_code updates only with err.
- Timeout: counter clears on every popped byte and in S_HUNT. In other states it increments each cycle rx_empty=1. When it reaches TIMEOUT_CYC-1: err=1, code 4 next cycle, state -> S_HUNT. The partial frame is discarded.
- Byte arrival and timeout expiry in the same cycle: the byte wins and the counter clears.
- Reset values: state S_HUNT, counter 0, all strobes 0, move_cell 0, move_player 0, err_code 0, frames_ok/frames_err 0.
- Reset asserted mid-frame: next state is S_HUNT, the partial frame is lost, and no strobe is emitted. rd_uart=0 while reset=1, so no byte is lost during reset.

Optional Feature:
- Macro: UART_FRAME_STATS_EN.
- Defined: frames_ok increments on each move_valid/new_game; frames_err increments on each err. Both saturate at 255 and clear only on reset.
- Undefined: no counter logic is built; both ports are tied to 8'd0.

Decomposition:
- Package uart_frame_pkg: SYNC_BYTE, TYPE_MOVE, TYPE_NEW_GAME, ERR_CHK/ERR_TYPE/ERR_ARG/ERR_TIMEOUT codes, state encoding, MAX_CELL=8.
- One sub-module: uart_frame_timer (TO_BITS counter with clear/enable inputs and an expire output, parameterised by TIMEOUT_CYC).

Test Plan:
- Push A5 01 14 15 back-to-back -> move_valid=1 for one cycle, 1 cycle after CHK pop; move_player=1, move_cell=4; no err; frames_ok=1 with macro.
- Push 00 FF A5 02 00 02 -> leading 00/FF dropped silently; new_game pulses once; err never asserts.
- Push A5 01 29 00 -> err=1, err_code=1. Then push A5 01 19 18 -> err_code=3 (cell 9). Then push A5 07 00 07 -> err_code=2.
- Push A5 01, then idle TIMEOUT_CYC cycles (TIMEOUT_CYC=50 in bench) -> err_code=4 at cycle 50. A following A5 01 22 23 is accepted (player 2, cell 2).
- Push A5 01 then assert reset 1 cycle with 3 bytes still in FIFO -> rd_uart=0 during reset, FSM in S_HUNT, no strobes; remaining bytes parsed afresh.
- 300 valid frames with UART_FRAME_STATS_EN -> frames_ok saturates at 255. Without the macro -> both counters read 0.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared constants, state encoding and the frame validation helper for uart_frame_rx.
package uart_frame_pkg;

  localparam logic [7:0] SYNC_BYTE     = 8'hA5;
  localparam logic [7:0] TYPE_MOVE     = 8'h01;
  localparam logic [7:0] TYPE_NEW_GAME = 8'h02;
  localparam logic [3:0] PLAYER_X      = 4'd1;
  localparam logic [3:0] PLAYER_O      = 4'd2;
  localparam logic [3:0] MAX_CELL      = 4'd8;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_CHK     = 3'd1;
  localparam logic [2:0] ERR_TYPE    = 3'd2;
  localparam logic [2:0] ERR_ARG     = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;

  typedef enum logic [1:0] {
    S_HUNT = 2'd0,
    S_TYPE = 2'd1,
    S_ARG  = 2'd2,
    S_CHK  = 2'd3
  } state_e;

  // Checksum outranks type, which outranks argument range.
  function automatic logic [2:0] frame_check(input logic [7:0] typ,
                                             input logic [7:0] arg,
                                             input logic [7:0] chk);
    logic [2:0] code;
    if (chk != (typ ^ arg)) begin
      code = ERR_CHK;
    end else if ((typ != TYPE_MOVE) && (typ != TYPE_NEW_GAME)) begin
      code = ERR_TYPE;
    end else if (typ == TYPE_MOVE) begin
      if (((arg[7:4] != PLAYER_X) && (arg[7:4] != PLAYER_O)) || (arg[3:0] > MAX_CELL)) begin
        code = ERR_ARG;
      end else begin
        code = ERR_NONE;
      end
    end else if (arg != 8'h00) begin
      code = ERR_ARG;
    end else begin
      code = ERR_NONE;
    end
    return code;
  endfunction

endpackage

// File: rtl/uart_frame_timer.sv
// Inter-byte timeout counter: clear wins over enable; expire flags the final idle cycle.
module uart_frame_timer
  import uart_frame_pkg::*;
#(
  parameter int TIMEOUT_CYC = 2_000_000,
  parameter int TO_BITS     = 21
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [TO_BITS-1:0] LAST_CNT = TO_BITS'(TIMEOUT_CYC - 1);
  localparam logic [TO_BITS-1:0] ONE_CNT  = TO_BITS'(1);

  logic [TO_BITS-1:0] cnt_q;
  logic [TO_BITS-1:0] cnt_d;

  // Next count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + ONE_CNT;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i & ~clr_i & (cnt_q == LAST_CNT);

endmodule

// File: rtl/uart_frame_rx.sv
// Parses SYNC/TYPE/ARG/CHK game frames popped from a FWFT RX FIFO.
// Optional frame statistics counters are built when UART_FRAME_STATS_EN is defined.
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter int TIMEOUT_CYC = 2_000_000,
  parameter int TO_BITS     = 21
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_empty,
  input  logic [7:0] r_data,
  output logic       rd_uart,
  output logic       move_valid,
  output logic [3:0] move_cell,
  output logic [1:0] move_player,
  output logic       new_game,
  output logic       err,
  output logic [2:0] err_code,
  output logic [7:0] frames_ok,
  output logic [7:0] frames_err
);

  state_e     state_q, state_d;
  logic [7:0] type_q, type_d;
  logic [7:0] arg_q, arg_d;
  logic       move_valid_q, move_valid_d;
  logic       new_game_q, new_game_d;
  logic       err_q, err_d;
  logic [2:0] err_code_q, err_code_d;
  logic [3:0] move_cell_q, move_cell_d;
  logic [1:0] move_player_q, move_player_d;
  logic       pop_s;
  logic       expire_s;
  logic [2:0] code_s;

  // Holding rd_uart low in reset keeps the FIFO head intact.
  assign pop_s   = ~rx_empty & ~reset;
  assign rd_uart = pop_s;
  assign code_s  = frame_check(type_q, arg_q, r_data);

  uart_frame_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_BITS     (TO_BITS)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (pop_s | (state_q == S_HUNT)),
    .en_i     (rx_empty & (state_q != S_HUNT)),
    .expire_o (expire_s)
  );

  // Frame FSM next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    type_d        = type_q;
    arg_d         = arg_q;
    move_valid_d  = 1'b0;
    new_game_d    = 1'b0;
    err_d         = 1'b0;
    err_code_d    = err_code_q;
    move_cell_d   = move_cell_q;
    move_player_d = move_player_q;
    case (state_q)
      S_HUNT: begin
        if (pop_s && (r_data == SYNC_BYTE)) begin
          state_d = S_TYPE;
        end else begin
          state_d = S_HUNT;
        end
      end
      S_TYPE, S_ARG, S_CHK: begin
        if (pop_s) begin
          if (state_q == S_TYPE) begin
            type_d  = r_data;
            state_d = S_ARG;
          end else if (state_q == S_ARG) begin
            arg_d   = r_data;
            state_d = S_CHK;
          end else begin
            state_d = S_HUNT;
            if (code_s != ERR_NONE) begin
              err_d      = 1'b1;
              err_code_d = code_s;
            end else if (type_q == TYPE_MOVE) begin
              move_valid_d  = 1'b1;
              move_cell_d   = arg_q[3:0];
              move_player_d = arg_q[5:4];
            end else begin
              new_game_d = 1'b1;
            end
          end
        end else if (expire_s) begin
          state_d    = S_HUNT;
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = S_HUNT;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_HUNT;
      type_q        <= 8'h00;
      arg_q         <= 8'h00;
      move_valid_q  <= 1'b0;
      new_game_q    <= 1'b0;
      err_q         <= 1'b0;
      err_code_q    <= 3'd0;
      move_cell_q   <= 4'd0;
      move_player_q <= 2'd0;
    end else begin
      state_q       <= state_d;
      type_q        <= type_d;
      arg_q         <= arg_d;
      move_valid_q  <= move_valid_d;
      new_game_q    <= new_game_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
      move_cell_q   <= move_cell_d;
      move_player_q <= move_player_d;
    end
  end

  assign move_valid  = move_valid_q;
  assign new_game    = new_game_q;
  assign err         = err_q;
  assign err_code    = err_code_q;
  assign move_cell   = move_cell_q;
  assign move_player = move_player_q;

`ifdef UART_FRAME_STATS_EN
  logic [7:0] frames_ok_q, frames_ok_d;
  logic [7:0] frames_err_q, frames_err_d;

  // Saturating counters step alongside the strobes they count.
  always_comb begin
    frames_ok_d  = frames_ok_q;
    frames_err_d = frames_err_q;
    if ((move_valid_d || new_game_d) && (frames_ok_q != 8'hFF)) begin
      frames_ok_d = frames_ok_q + 8'd1;
    end else begin
      frames_ok_d = frames_ok_q;
    end
    if (err_d && (frames_err_q != 8'hFF)) begin
      frames_err_d = frames_err_q + 8'd1;
    end else begin
      frames_err_d = frames_err_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      frames_ok_q  <= 8'd0;
      frames_err_q <= 8'd0;
    end else begin
      frames_ok_q  <= frames_ok_d;
      frames_err_q <= frames_err_d;
    end
  end

  assign frames_ok  = frames_ok_q;
  assign frames_err = frames_err_q;
`else
  assign frames_ok  = 8'd0;
  assign frames_err = 8'd0;
`endif

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx; the FIFO head is driven on the falling edge.
module tb_uart_frame_rx;

  localparam int TO_CYC = 50;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_empty;
  logic [7:0] r_data;
  logic       rd_uart;
  logic       move_valid;
  logic [3:0] move_cell;
  logic [1:0] move_player;
  logic       new_game;
  logic       err;
  logic [2:0] err_code;
  logic [7:0] frames_ok;
  logic [7:0] frames_err;

  int checks = 0;
  int errors = 0;
  int mv_cnt = 0;
  int ng_cnt = 0;
  int er_cnt = 0;

  uart_frame_rx #(.TIMEOUT_CYC(TO_CYC), .TO_BITS(6)) dut (
    .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data),
    .rd_uart(rd_uart), .move_valid(move_valid), .move_cell(move_cell),
    .move_player(move_player), .new_game(new_game), .err(err),
    .err_code(err_code), .frames_ok(frames_ok), .frames_err(frames_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (move_valid) mv_cnt++;
    if (new_game) ng_cnt++;
    if (err) er_cnt++;
  end

  task send(input logic [7:0] b);
    rx_empty = 1'b0;
    r_data   = b;
    @(negedge clk);
  endtask

  task send_frame(input logic [31:0] f);
    send(f[31:24]); send(f[23:16]); send(f[15:8]); send(f[7:0]);
    rx_empty = 1'b1;
  endtask

  task idle(input int n);
    rx_empty = 1'b1;
    r_data   = 8'h00;
    repeat (n) @(negedge clk);
  endtask

  task test_reset;
    reset = 1'b1; rx_empty = 1'b1; r_data = 8'h00;
    repeat (3) @(negedge clk);
    rx_empty = 1'b0; r_data = 8'hA5; #1;
    checks++;
    if (rd_uart !== 1'b0) begin errors++; $display("FAIL reset_rd_uart got=%b exp=0", rd_uart); end
    checks++;
    if ({move_valid, new_game, err, err_code, move_cell, move_player} !== 12'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%b%b%b %0d %0d %0d exp=all zero",
               move_valid, new_game, err, err_code, move_cell, move_player);
    end
    checks++;
    if ({frames_ok, frames_err} !== 16'd0) begin errors++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", frames_ok, frames_err); end
    @(negedge clk);
    rx_empty = 1'b1; reset = 1'b0;
    @(negedge clk);
  endtask

  task test_move;
    int m0, e0;
    m0 = mv_cnt; e0 = er_cnt;
    send_frame(32'hA5011415);
    checks++;
    if ({move_valid, move_player, move_cell} !== {1'b1, 2'd1, 4'd4}) begin
      errors++;
      $display("FAIL move_strobe got=v%b p%0d c%0d exp=v1 p1 c4", move_valid, move_player, move_cell);
    end
    checks++;
`ifdef UART_FRAME_STATS_EN
    if (frames_ok !== 8'd1) begin errors++; $display("FAIL move_frames_ok got=%0d exp=1", frames_ok); end
`else
    if (frames_ok !== 8'd0) begin errors++; $display("FAIL move_frames_ok got=%0d exp=0", frames_ok); end
`endif
    idle(1);
    checks++;
    if (move_valid !== 1'b0) begin errors++; $display("FAIL move_one_cycle got=%b exp=0", move_valid); end
    idle(1);
    checks++;
    if ((mv_cnt - m0 != 1) || (er_cnt != e0)) begin
      errors++;
      $display("FAIL move_pulse_count got=mv%0d err%0d exp=mv1 err0", mv_cnt - m0, er_cnt - e0);
    end
  endtask

  task test_hunt_new_game;
    int n0, e0;
    n0 = ng_cnt; e0 = er_cnt;
    send(8'h00); send(8'hFF);
    send_frame(32'hA5020002);
    checks++;
    if ({new_game, err} !== 2'b10) begin errors++; $display("FAIL hunt_new_game got=ng%b err%b exp=ng1 err0", new_game, err); end
    idle(2);
    checks++;
    if ((ng_cnt - n0 != 1) || (er_cnt != e0) || (move_cell !== 4'd4)) begin
      errors++;
      $display("FAIL hunt_counts got=ng%0d err%0d cell%0d exp=ng1 err0 cell4", ng_cnt - n0, er_cnt - e0, move_cell);
    end
  endtask

  task test_errors;
    logic [31:0] frames [3];
    logic [2:0]  codes  [3];
    int m0, e0;
    frames[0] = 32'hA5012900; codes[0] = 3'd1;
    frames[1] = 32'hA5011918; codes[1] = 3'd3;
    frames[2] = 32'hA5070007; codes[2] = 3'd2;
    m0 = mv_cnt; e0 = er_cnt;
    for (int i = 0; i < 3; i++) begin
      send_frame(frames[i]);
      checks++;
      if ({err, err_code} !== {1'b1, codes[i]}) begin
        errors++;
        $display("FAIL err_frame%0d got=err%b code%0d exp=err1 code%0d", i, err, err_code, codes[i]);
      end
      idle(1);
      checks++;
      if ({err, err_code} !== {1'b0, codes[i]}) begin
        errors++;
        $display("FAIL err_hold%0d got=err%b code%0d exp=err0 code%0d", i, err, err_code, codes[i]);
      end
    end
    idle(1);
    checks++;
    if ((mv_cnt != m0) || (er_cnt - e0 != 3) || (move_cell !== 4'd4) || (move_player !== 2'd1)) begin
      errors++;
      $display("FAIL err_side_effects got=mv%0d err%0d cell%0d player%0d exp=mv0 err3 cell4 player1",
               mv_cnt - m0, er_cnt - e0, move_cell, move_player);
    end
    checks++;
`ifdef UART_FRAME_STATS_EN
    if (frames_err !== 8'd3) begin errors++; $display("FAIL err_frames_err got=%0d exp=3", frames_err); end
`else
    if (frames_err !== 8'd0) begin errors++; $display("FAIL err_frames_err got=%0d exp=0", frames_err); end
`endif
  endtask

  task test_timeout;
    send(8'hA5); send(8'h01);
    idle(TO_CYC - 1);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL timeout_early got=%b exp=0", err); end
    idle(1);
    checks++;
    if ({err, err_code} !== {1'b1, 3'd4}) begin errors++; $display("FAIL timeout_fire got=err%b code%0d exp=err1 code4", err, err_code); end
    idle(1);
    send_frame(32'hA5012223);
    checks++;
    if ({move_valid, move_player, move_cell} !== {1'b1, 2'd2, 4'd2}) begin
      errors++;
      $display("FAIL timeout_recover got=v%b p%0d c%0d exp=v1 p2 c2", move_valid, move_player, move_cell);
    end
    idle(2);
  endtask

  task test_reset_midframe;
    int m0, n0, e0;
    send(8'hA5); send(8'h01);
    reset = 1'b1; rx_empty = 1'b0; r_data = 8'h14; #1;
    checks++;
    if (rd_uart !== 1'b0) begin errors++; $display("FAIL midreset_rd_uart got=%b exp=0", rd_uart); end
    @(negedge clk);
    reset = 1'b0;
    m0 = mv_cnt; n0 = ng_cnt; e0 = er_cnt;
    send(8'h14); send(8'h15); send(8'h16);
    idle(2);
    checks++;
    if ((mv_cnt != m0) || (ng_cnt != n0) || (er_cnt != e0)) begin
      errors++;
      $display("FAIL midreset_strobes got=mv%0d ng%0d err%0d exp=0 0 0", mv_cnt - m0, ng_cnt - n0, er_cnt - e0);
    end
    checks++;
    if ({move_cell, move_player, err_code, frames_ok} !== 17'd0) begin
      errors++;
      $display("FAIL midreset_cleared got=c%0d p%0d code%0d ok%0d exp=0 0 0 0", move_cell, move_player, err_code, frames_ok);
    end
    send_frame(32'hA5020002);
    checks++;
    if (new_game !== 1'b1) begin errors++; $display("FAIL midreset_fresh got=%b exp=1", new_game); end
    idle(2);
  endtask

  task test_back_to_back;
    int n0;
    n0 = ng_cnt;
    for (int i = 0; i < 300; i++) begin
      send(8'hA5); send(8'h02); send(8'h00); send(8'h02);
    end
    idle(2);
    checks++;
    if (ng_cnt - n0 != 300) begin errors++; $display("FAIL b2b_count got=%0d exp=300", ng_cnt - n0); end
    checks++;
`ifdef UART_FRAME_STATS_EN
    if ({frames_ok, frames_err} !== {8'd255, 8'd0}) begin
      errors++; $display("FAIL b2b_stats got=%0d/%0d exp=255/0", frames_ok, frames_err);
    end
`else
    if ({frames_ok, frames_err} !== 16'd0) begin
      errors++; $display("FAIL b2b_stats got=%0d/%0d exp=0/0", frames_ok, frames_err);
    end
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; rx_empty = 1'b1; r_data = 8'h00;
    @(negedge clk);
    test_reset;
    test_move;
    test_hunt_new_game;
    test_errors;
    test_timeout;
    test_reset_midframe;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
